// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator for the decode stage.
// Takes a 32-bit instruction plus its PC over a valid/ready handshake and
// delivers an XLEN-wide immediate, a format code and an illegal flag after
// STAGES register stages (1 or 2). XLEN other than 64 behaves as 32 and
// STAGES other than 2 behaves as 1.
module imm_gen_stage #(
  parameter int XLEN     = 32,
  parameter int STAGES   = 1,
  parameter int ZICSR_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_e;

  // How the raw field is widened to XLEN: zero fill, or sign fill from the
  // top bit of a 12/13/21/32-bit field.
  typedef enum logic [2:0] {
    EXT_ZERO,
    EXT_S12,
    EXT_S13,
    EXT_S21,
    EXT_S32
  } ext_e;

  localparam bit RV64  = (XLEN == 64);
  localparam bit ZICSR = (ZICSR_EN != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  fmt_e        dec_fmt;
  ext_e        dec_ext;
  logic [31:0] dec_raw;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  function automatic logic [XLEN-1:0] extend(input ext_e k, input logic [31:0] raw);
    logic [XLEN-1:0] r;
    case (k)
      EXT_S12: begin r = {XLEN{raw[11]}}; r[11:0] = raw[11:0]; end
      EXT_S13: begin r = {XLEN{raw[12]}}; r[12:0] = raw[12:0]; end
      EXT_S21: begin r = {XLEN{raw[20]}}; r[20:0] = raw[20:0]; end
      EXT_S32: begin r = {XLEN{raw[31]}}; r[31:0] = raw;       end
      default: begin r = '0;              r[31:0] = raw;       end
    endcase
    return r;
  endfunction

  // Classify the instruction and gather its immediate bits, still unextended.
  always_comb begin
    dec_fmt = FMT_ILL;
    dec_ext = EXT_ZERO;
    dec_raw = '0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OP_LOAD, OP_JALR, OP_FENCE: begin
          dec_fmt = FMT_I;
          dec_ext = EXT_S12;
          dec_raw = {20'b0, inst[31:20]};
        end
        OP_IMM: begin
          if (is_shift) begin
            if (RV64) begin
              dec_fmt = FMT_I;
              dec_raw = {26'b0, inst[25:20]};
            end else if (!inst[25]) begin
              dec_fmt = FMT_I;
              dec_raw = {27'b0, inst[24:20]};
            end
          end else begin
            dec_fmt = FMT_I;
            dec_ext = EXT_S12;
            dec_raw = {20'b0, inst[31:20]};
          end
        end
        OP_IMM32: begin
          if (RV64) begin
            if (is_shift) begin
              if (!inst[25]) begin
                dec_fmt = FMT_I;
                dec_raw = {27'b0, inst[24:20]};
              end
            end else begin
              dec_fmt = FMT_I;
              dec_ext = EXT_S12;
              dec_raw = {20'b0, inst[31:20]};
            end
          end
        end
        OP_STORE: begin
          dec_fmt = FMT_S;
          dec_ext = EXT_S12;
          dec_raw = {20'b0, inst[31:25], inst[11:7]};
        end
        OP_BRANCH: begin
          dec_fmt = FMT_B;
          dec_ext = EXT_S13;
          dec_raw = {19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          dec_fmt = FMT_U;
          dec_ext = EXT_S32;
          dec_raw = {inst[31:12], 12'b0};
        end
        OP_JAL: begin
          dec_fmt = FMT_J;
          dec_ext = EXT_S21;
          dec_raw = {11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        OP_SYSTEM: begin
          if (funct3 == 3'b000) begin
            dec_fmt = FMT_NONE;
          end else if (ZICSR && (funct3 != 3'b100)) begin
            if (funct3[2]) begin
              dec_fmt = FMT_Z;
              dec_raw = {27'b0, inst[19:15]};
            end else begin
              dec_fmt = FMT_I;
              dec_raw = {20'b0, inst[31:20]};
            end
          end
        end
        OP_OP: begin
          dec_fmt = FMT_NONE;
        end
        OP_OP32: begin
          if (RV64) begin
            dec_fmt = FMT_NONE;
          end
        end
        default: begin
          dec_fmt = FMT_ILL;
        end
      endcase
    end
  end

  assign illegal = (fmt == FMT_ILL);

  if (STAGES == 2) begin : g_two
    logic            v1_q, v1_d, v2_q, v2_d;
    logic            rdy1, rdy2;
    fmt_e            fmt1_q;
    ext_e            ext1_q;
    logic [31:0]     raw1_q;
    logic [XLEN-1:0] pc1_q;
    fmt_e            fmt2_q;
    logic [XLEN-1:0] imm2_q, pc2_q;

    assign rdy2     = !v2_q || out_ready;
    assign rdy1     = !v1_q || rdy2;
    assign in_ready = rdy1;

    // Next-state of the two valid bits; flush empties both stages.
    always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      if (flush) begin
        v1_d = 1'b0;
        v2_d = 1'b0;
      end else begin
        if (rdy1) v1_d = in_valid;
        if (rdy2) v2_d = v1_q;
      end
    end

    // Valid bits, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
      end else begin
        v1_q <= v1_d;
        v2_q <= v2_d;
      end
    end

    // Stage 1 holds the format class and raw immediate field.
    always_ff @(posedge clk) begin
      if (in_valid && rdy1 && !flush) begin
        fmt1_q <= dec_fmt;
        ext1_q <= dec_ext;
        raw1_q <= dec_raw;
        pc1_q  <= pc;
      end
    end

    // Stage 2 widens the field to XLEN; reset values appear on the outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        fmt2_q <= FMT_NONE;
        imm2_q <= '0;
        pc2_q  <= '0;
      end else if (v1_q && rdy2 && !flush) begin
        fmt2_q <= fmt1_q;
        imm2_q <= extend(ext1_q, raw1_q);
        pc2_q  <= pc1_q;
      end
    end

    assign out_valid = v2_q;
    assign imm       = imm2_q;
    assign fmt       = fmt2_q;
    assign pc_out    = pc2_q;
  end else begin : g_one
    logic            v_q, v_d;
    logic            rdy;
    fmt_e            fmt_q;
    logic [XLEN-1:0] imm_q, pc_q;

    assign rdy      = !v_q || out_ready;
    assign in_ready = rdy;

    // Next-state of the valid bit; flush empties the stage.
    always_comb begin
      v_d = v_q;
      if (flush) begin
        v_d = 1'b0;
      end else if (rdy) begin
        v_d = in_valid;
      end
    end

    // Single stage: decode and widen in one go; reset values appear on the outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        fmt_q <= FMT_NONE;
        imm_q <= '0;
        pc_q  <= '0;
      end else begin
        v_q <= v_d;
        if (in_valid && rdy && !flush) begin
          fmt_q <= dec_fmt;
          imm_q <= extend(dec_ext, dec_raw);
          pc_q  <= pc;
        end
      end
    end

    assign out_valid = v_q;
    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign pc_out    = pc_q;
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three single-stage variants (RV32,
// RV32 without CSR decode, RV64) share one stimulus; a two-stage RV32
// instance covers backpressure, flush and reset.
module tb_imm_gen_stage;

  logic clk;
  logic rst;

  // Shared stimulus for the single-stage instances
  logic        a_valid, a_ordy, a_flush;
  logic [31:0] a_inst, a_pc;
  logic [63:0] a_pc64;

  logic        r32_ready, r32_ovalid, r32_ill;
  logic [31:0] r32_imm, r32_pc;
  logic [2:0]  r32_fmt;

  logic        rz_ready, rz_ovalid, rz_ill;
  logic [31:0] rz_imm, rz_pc;
  logic [2:0]  rz_fmt;

  logic        r64_ready, r64_ovalid, r64_ill;
  logic [63:0] r64_imm, r64_pc;
  logic [2:0]  r64_fmt;

  // Two-stage instance
  logic        b_valid, b_ordy, b_flush;
  logic [31:0] b_inst, b_pc;
  logic        b_ready, b_ovalid, b_ill;
  logic [31:0] b_imm, b_pcout;
  logic [2:0]  b_fmt;

  int n_checks;
  int n_errors;

  imm_gen_stage #(.XLEN(32), .STAGES(1), .ZICSR_EN(1)) u32 (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_valid), .in_ready(r32_ready),
    .inst(a_inst), .pc(a_pc), .out_valid(r32_ovalid), .out_ready(a_ordy),
    .imm(r32_imm), .fmt(r32_fmt), .pc_out(r32_pc), .illegal(r32_ill));

  imm_gen_stage #(.XLEN(32), .STAGES(1), .ZICSR_EN(0)) uz (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_valid), .in_ready(rz_ready),
    .inst(a_inst), .pc(a_pc), .out_valid(rz_ovalid), .out_ready(a_ordy),
    .imm(rz_imm), .fmt(rz_fmt), .pc_out(rz_pc), .illegal(rz_ill));

  imm_gen_stage #(.XLEN(64), .STAGES(1), .ZICSR_EN(1)) u64 (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_valid), .in_ready(r64_ready),
    .inst(a_inst), .pc(a_pc64), .out_valid(r64_ovalid), .out_ready(a_ordy),
    .imm(r64_imm), .fmt(r64_fmt), .pc_out(r64_pc), .illegal(r64_ill));

  imm_gen_stage #(.XLEN(32), .STAGES(2), .ZICSR_EN(1)) u2 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_valid), .in_ready(b_ready),
    .inst(b_inst), .pc(b_pc), .out_valid(b_ovalid), .out_ready(b_ordy),
    .imm(b_imm), .fmt(b_fmt), .pc_out(b_pcout), .illegal(b_ill));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the single-stage trio and check it a cycle later.
  // val is the legal immediate at 64 bits; an illegal result must read as 0.
  task automatic vec(input logic [31:0] i, input logic [63:0] val,
                     input logic [2:0] f32, input logic [2:0] fz, input logic [2:0] f64);
    logic [63:0] e32, ez, e64;
    a_inst = i;
    a_pc   = a_pc + 32'd4;
    a_pc64 = {32'h0000_0001, a_pc};
    step();
    e32 = (f32 == 3'd7) ? 64'd0 : {32'd0, val[31:0]};
    ez  = (fz  == 3'd7) ? 64'd0 : {32'd0, val[31:0]};
    e64 = (f64 == 3'd7) ? 64'd0 : val;
    chk($sformatf("u32 valid %h", i), {63'd0, r32_ovalid}, 64'd1);
    chk($sformatf("u32 imm %h", i), {32'd0, r32_imm}, e32);
    chk($sformatf("u32 fmt %h", i), {61'd0, r32_fmt}, {61'd0, f32});
    chk($sformatf("u32 illegal %h", i), {63'd0, r32_ill}, {63'd0, (f32 == 3'd7)});
    chk($sformatf("u32 pc %h", i), {32'd0, r32_pc}, {32'd0, a_pc});
    chk($sformatf("uz imm %h", i), {32'd0, rz_imm}, ez);
    chk($sformatf("uz fmt %h", i), {61'd0, rz_fmt}, {61'd0, fz});
    chk($sformatf("u64 imm %h", i), r64_imm, e64);
    chk($sformatf("u64 fmt %h", i), {61'd0, r64_fmt}, {61'd0, f64});
    chk($sformatf("u64 illegal %h", i), {63'd0, r64_ill}, {63'd0, (f64 == 3'd7)});
    chk($sformatf("u64 pc %h", i), r64_pc, a_pc64);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_ordy = 1'b0; a_flush = 1'b0;
    a_inst = 32'h0; a_pc = 32'h0000_0100; a_pc64 = 64'h0;
    b_valid = 1'b0; b_ordy = 1'b0; b_flush = 1'b0;
    b_inst = 32'h0; b_pc = 32'h0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst u32 out_valid", {63'd0, r32_ovalid}, 64'd0);
    chk("rst u32 imm", {32'd0, r32_imm}, 64'd0);
    chk("rst u32 fmt", {61'd0, r32_fmt}, 64'd6);
    chk("rst u32 pc_out", {32'd0, r32_pc}, 64'd0);
    chk("rst u32 illegal", {63'd0, r32_ill}, 64'd0);
    chk("rst u32 in_ready", {63'd0, r32_ready}, 64'd1);
    chk("rst u64 fmt", {61'd0, r64_fmt}, 64'd6);
    chk("rst u2 out_valid", {63'd0, b_ovalid}, 64'd0);
    chk("rst u2 fmt", {61'd0, b_fmt}, 64'd6);
    chk("rst u2 in_ready", {63'd0, b_ready}, 64'd1);

    // Back-to-back decode on the single-stage instances
    a_valid = 1'b1;
    a_ordy  = 1'b1;
    vec(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd0, 3'd0); // addi -1
    vec(32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 3'd1, 3'd1); // sw -4
    vec(32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 3'd4, 3'd4); // j -4
    vec(32'h4030D093, 64'h0000_0000_0000_0003, 3'd0, 3'd0, 3'd0); // srai 3
    vec(32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 3'd2, 3'd2); // beq -4
    vec(32'h3002D073, 64'h0000_0000_0000_0005, 3'd5, 3'd7, 3'd5); // csrrwi zimm 5
    vec(32'hC0002073, 64'h0000_0000_0000_0C00, 3'd0, 3'd7, 3'd0); // csrrs csr 0xC00, zero-extended
    vec(32'h00000073, 64'h0000_0000_0000_0000, 3'd6, 3'd6, 3'd6); // ecall
    vec(32'h00004073, 64'h0000_0000_0000_0000, 3'd7, 3'd7, 3'd7); // SYSTEM funct3=100
    vec(32'h00000010, 64'h0000_0000_0000_0000, 3'd7, 3'd7, 3'd7); // nop with bits[1:0]=00
    vec(32'h0000007F, 64'h0000_0000_0000_0000, 3'd7, 3'd7, 3'd7); // unknown opcode
    vec(32'h002081B3, 64'h0000_0000_0000_0000, 3'd6, 3'd6, 3'd6); // add
    vec(32'h0000003B, 64'h0000_0000_0000_0000, 3'd7, 3'd7, 3'd6); // OP-32
    vec(32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 3'd7, 3'd0); // addiw -1
    vec(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 3'd3, 3'd3); // lui 0x80000
    vec(32'h02809093, 64'h0000_0000_0000_0028, 3'd7, 3'd7, 3'd0); // slli 40
    a_valid = 1'b0;

    // Two-stage: latency, backpressure and ordering
    b_ordy = 1'b1; b_valid = 1'b1;
    b_inst = 32'hFFF00093; b_pc = 32'h1000;
    step();
    chk("u2 latency not early", {63'd0, b_ovalid}, 64'd0);
    chk("u2 in_ready streaming", {63'd0, b_ready}, 64'd1);
    b_inst = 32'hFE20AE23; b_pc = 32'h1004;
    step();
    chk("u2 e0 valid", {63'd0, b_ovalid}, 64'd1);
    chk("u2 e0 imm", {32'd0, b_imm}, 64'hFFFF_FFFF);
    chk("u2 e0 fmt", {61'd0, b_fmt}, 64'd0);
    chk("u2 e0 pc", {32'd0, b_pcout}, 64'h1000);
    b_inst = 32'h800000B7; b_pc = 32'h1008; b_ordy = 1'b0;
    step();
    chk("u2 stall1 in_ready", {63'd0, b_ready}, 64'd0);
    chk("u2 stall1 imm held", {32'd0, b_imm}, 64'hFFFF_FFFF);
    step();
    chk("u2 stall2 in_ready", {63'd0, b_ready}, 64'd0);
    chk("u2 stall2 valid", {63'd0, b_ovalid}, 64'd1);
    step();
    chk("u2 stall3 pc held", {32'd0, b_pcout}, 64'h1000);
    b_ordy = 1'b1;
    step();
    chk("u2 e1 imm", {32'd0, b_imm}, 64'hFFFF_FFFC);
    chk("u2 e1 fmt", {61'd0, b_fmt}, 64'd1);
    chk("u2 e1 pc", {32'd0, b_pcout}, 64'h1004);
    b_inst = 32'h3002D073; b_pc = 32'h100C;
    step();
    chk("u2 e2 imm", {32'd0, b_imm}, 64'h8000_0000);
    chk("u2 e2 fmt", {61'd0, b_fmt}, 64'd3);
    chk("u2 e2 pc", {32'd0, b_pcout}, 64'h1008);
    b_valid = 1'b0;
    step();
    chk("u2 e3 valid", {63'd0, b_ovalid}, 64'd1);
    chk("u2 e3 imm", {32'd0, b_imm}, 64'd5);
    chk("u2 e3 fmt", {61'd0, b_fmt}, 64'd5);
    chk("u2 e3 pc", {32'd0, b_pcout}, 64'h100C);
    step();
    chk("u2 drained", {63'd0, b_ovalid}, 64'd0);

    // Flush with two entries in flight and an input presented
    b_valid = 1'b1; b_inst = 32'h00500093; b_pc = 32'h2000;
    step();
    b_inst = 32'h00600093; b_pc = 32'h2004;
    step();
    chk("u2 pre-flush imm", {32'd0, b_imm}, 64'd5);
    b_inst = 32'h00700093; b_pc = 32'h2008; b_flush = 1'b1;
    step();
    chk("u2 flush out_valid", {63'd0, b_ovalid}, 64'd0);
    b_flush = 1'b0; b_valid = 1'b0;
    step();
    chk("u2 flush input dropped", {63'd0, b_ovalid}, 64'd0);
    step();
    chk("u2 flush still empty", {63'd0, b_ovalid}, 64'd0);

    // Reset mid-stream
    b_valid = 1'b1; b_inst = 32'h00800093; b_pc = 32'h3000;
    step();
    b_inst = 32'h00900093; b_pc = 32'h3004;
    step();
    chk("u2 pre-rst imm", {32'd0, b_imm}, 64'd8);
    b_ordy = 1'b0; b_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("u2 rst out_valid", {63'd0, b_ovalid}, 64'd0);
    chk("u2 rst fmt", {61'd0, b_fmt}, 64'd6);
    chk("u2 rst imm", {32'd0, b_imm}, 64'd0);
    chk("u2 rst pc_out", {32'd0, b_pcout}, 64'd0);
    chk("u2 rst illegal", {63'd0, b_ill}, 64'd0);
    chk("u2 rst in_ready", {63'd0, b_ready}, 64'd1);
    step();
    chk("u2 rst no stale entry", {63'd0, b_ovalid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts a 32-bit instruction and its PC through a valid/ready handshake.
- Produces an XLEN-wide immediate, a format code and an illegal flag after STAGES register stages.
- Adds RV64 support, shamt-only shift immediates, CSR zimm, illegal detection, stall backpressure and flush over the previous combinational generator; sits between fetch/IF-ID and the ID/EX register.

Parameters:
- XLEN, 32: datapath width; only 32 or 64 are legal.
- STAGES, 1: number of pipeline register stages; only 1 or 2 are legal.
- ZICSR_EN, 1: 1 decodes SYSTEM CSR immediates; 0 treats SYSTEM opcode with funct3!=0 as illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight entries.
- in_valid  in  1  inst/pc valid.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  instruction address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- imm  out  XLEN  generated immediate.
- fmt  out  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z, 6=NONE, 7=ILLEGAL.
- pc_out  out  XLEN  pc carried with the entry.
- illegal  out  1  entry is undecodable; equals (fmt==7).

Behaviour:
- Reset:
  - Synchronous, active-high: on a clk edge with rst=1, all stage valid bits clear.
  - Outputs: out_valid=0, imm=0, fmt=6, pc_out=0, illegal=0.
  - in_ready=1 in the cycle after reset.
  - rst overrides flush and any handshake in the same cycle; in-flight entries are dropped.
- Handshake:
  - Input accepts on in_valid & in_ready; output transfers on out_valid & out_ready.
  - Each stage k has valid_k and ready_k = !valid_k | ready_{k+1}; the last stage uses out_ready.
  - in_ready = ready_0, purely combinational from valid bits and out_ready; no combinational path from in_valid.
  - A stage loads when its upstream is valid and it is ready; it holds its payload while valid and not ready.
- Latency: an accepted instruction appears at out_valid exactly STAGES cycles later when out_ready is held at 1. Throughput is 1 per cycle.
- STAGES=2:
  - Stage 1 registers opcode class and raw fields.
  - Stage 2 performs sign-extension to XLEN.
- Flush:
  - Clears every valid bit on the next edge; payload registers are don't-care.
  - An input presented in the flush cycle is not accepted, regardless of in_ready.
  - out_valid is 0 in the cycle after flush.
- Illegal and shift rules:
  - inst[1:0]!=2'b11 gives fmt=7, imm=0.
- Decode rules (opcode = inst[6:0]; sext = sign-extend from inst[31] to XLEN):
  - 0000011 load, 1100111 JALR, 0001111 FENCE: I, sext(inst[31:20]).
  - 0010011 OP-IMM: I, sext(inst[31:20]), except funct3=001 or 101, where imm = zero-extended shamt.
    - Shamt is inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64.
    - For XLEN=32, inst[25]=1 on a shift is illegal.
  - 0011011 OP-IMM-32 (XLEN=64 only; otherwise illegal): as OP-IMM, with 5-bit shamt.
  - 0100011: S, sext({inst[31:25],inst[11:7]}).
  - 1100011: B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111: U, sext({inst[31:12],12'b0}); the upper 32 bits are sign-filled for XLEN=64.
  - 1101111: J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1110011 SYSTEM:
    - funct3=000: NONE, imm=0.
    - funct3=1xx: Z, zero-extended inst[19:15].
    - funct3=0x1 or 010: I, zero-extended inst[31:20] (CSR address).
    - funct3=100: illegal.
  - 0110011, and 0111011 (XLEN=64): NONE, imm=0.
  - Any other opcode: ILLEGAL, imm=0.
- pc_out travels unmodified alongside its instruction.

Test Plan:
- XLEN=32, STAGES=1: inst=0xFFF00093 (addi -1), out_ready=1 -> one cycle later out_valid=1, imm=0xFFFFFFFF, fmt=0, illegal=0.
- Back-to-back 0xFE20AE23 (sw -4), 0xFFDFF06F (j -4), 0x4030D093 (srai 3) -> consecutive cycles give imm=0xFFFFFFFC/fmt=1, 0xFFFFFFFC/fmt=4, 0x00000003/fmt=0.
- 0x3002D073 (csrrwi) -> imm=5, fmt=5. With ZICSR_EN=0 -> fmt=7, illegal=1. Inst 0x00000013 with bits[1:0] forced to 00 -> fmt=7.
- STAGES=2, stream of 4 instructions, out_ready=0 for 3 cycles mid-stream -> in_ready falls after both stages fill. No entry lost or duplicated; order is preserved; latency is 2 once out_ready=1.
- Flush with 2 entries in flight plus in_valid=1 -> next cycle out_valid=0 and the presented input is not accepted. Assert rst mid-stream -> out_valid=0, fmt=6, in_ready=1 on the following cycle.
- XLEN=64: 0x800000B7 (lui 0x80000) -> imm=0xFFFFFFFF80000000. slli with shamt 40 -> imm=40.
